// File: rtl/serial_pkg.sv
// serial_pkg
// Shared types and constants for the CPU serial transmit path.
//   tx_state_t       : transmit FSM state encoding
//   UART_IDLE_LEVEL  : line level for idle and stop bits
//   UART_START_LEVEL : line level for the start bit
//   WORD_W / BYTE_W  : CPU word width and UART byte width
//   even_parity()    : parity bit that makes the count of ones even
package serial_pkg;

  localparam int WORD_W = 16;
  localparam int BYTE_W = 8;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  function automatic logic even_parity(input logic [BYTE_W-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/serial_tx_fifo.sv
// serial_tx_fifo
// Synchronous word FIFO that buffers CPU writes ahead of the UART serializer.
// pop_data always shows the oldest word (first-word fall-through), so the
// consumer may load it on the same edge it pops.
// Ports:
//   Clock, Reset : system clock, asynchronous active-low reset
//   push         : write one word (ignored while full)
//   push_data    : word to write
//   pop          : remove the oldest word (ignored while empty)
//   pop_data     : oldest word
//   count        : number of stored words, 0..FIFO_DEPTH
//   full         : registered, high when count == FIFO_DEPTH
//   empty        : high when count == 0
module serial_tx_fifo
  import serial_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  localparam int PTR_W = $clog2(FIFO_DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              push,
  input  logic [WORD_W-1:0] push_data,
  input  logic              pop,
  output logic [WORD_W-1:0] pop_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  cnt_next;
  logic              do_push;
  logic              do_pop;

  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  always_comb begin
    cnt_next = count;
    case ({do_push, do_pop})
      2'b10:   cnt_next = count + 1'b1;
      2'b01:   cnt_next = count - 1'b1;
      default: cnt_next = count;
    endcase
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= cnt_next;
      full  <= (cnt_next == CNT_W'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge Clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/serial_word_tx.sv
// serial_word_tx
// Transmit end of the CPU serial port. 16-bit words written by the CPU are
// queued in serial_tx_fifo and sent on one UART line as two frames, low byte
// first, with no gap between bytes or between back-to-back words.
// Build option: define SERIAL_TX_PARITY_EN to append an even-parity bit to
// every frame (8E1); otherwise frames are 8N1.
// Ports:
//   Clock       : system clock
//   Reset       : asynchronous active-low reset
//   SerialWrite : write strobe, one word per high cycle
//   SerialData  : word sampled with SerialWrite
//   Tx          : registered UART line, idle high
//   Busy        : registered, FIFO non-empty or frame in progress
//   Full        : registered, FIFO holds FIFO_DEPTH words
//   Overflow    : sticky, a write was dropped because the FIFO was full
module serial_word_tx
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              SerialWrite,
  input  logic [WORD_W-1:0] SerialData,
  output logic              Tx,
  output logic              Busy,
  output logic              Full,
  output logic              Overflow
);

  localparam int TMR_W = $clog2(CLKS_PER_BIT);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  tx_state_t         state;
  logic [TMR_W-1:0]  bit_tmr;
  logic [2:0]        bit_idx;
  logic              hi_sel;
  logic [WORD_W-1:0] hold_word;
  logic [BYTE_W-1:0] cur_byte;
  logic              bit_end;
  logic              push;
  logic              pop;
  logic [WORD_W-1:0] fifo_data;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;

  // A write seen while Full is high is dropped even if a pop frees a slot
  // on the same edge.
  assign push     = SerialWrite & ~Full;
  assign bit_end  = (bit_tmr == TMR_W'(CLKS_PER_BIT - 1));
  assign cur_byte = hi_sel ? hold_word[WORD_W-1:BYTE_W] : hold_word[BYTE_W-1:0];

  // Words are fetched from IDLE, or at the end of a high byte's stop bit so
  // the next word starts without an idle gap.
  assign pop = ((state == ST_IDLE) && (fifo_count != '0)) ||
               ((state == ST_STOP) && bit_end && hi_sel && !fifo_empty);

  serial_tx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .Clock     (Clock),
    .Reset     (Reset),
    .push      (push),
    .push_data (SerialData),
    .pop       (pop),
    .pop_data  (fifo_data),
    .count     (fifo_count),
    .full      (Full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge Clock) begin
    if (pop) hold_word <= fifo_data;
  end

  // Tx is registered from the current state, so the line trails the state
  // register by one cycle while every bit still lasts CLKS_PER_BIT cycles.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state    <= ST_IDLE;
      bit_tmr  <= '0;
      bit_idx  <= '0;
      hi_sel   <= 1'b0;
      Tx       <= UART_IDLE_LEVEL;
      Busy     <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      if (SerialWrite && Full) Overflow <= 1'b1;

      case (state)
        ST_START:  Tx <= UART_START_LEVEL;
        ST_DATA:   Tx <= cur_byte[bit_idx];
`ifdef SERIAL_TX_PARITY_EN
        ST_PARITY: Tx <= even_parity(cur_byte);
`endif
        default:   Tx <= UART_IDLE_LEVEL;
      endcase

      if (state == ST_IDLE || bit_end) bit_tmr <= '0;
      else                             bit_tmr <= bit_tmr + 1'b1;

      Busy <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            hi_sel <= 1'b0;
            state  <= ST_START;
          end else begin
            Busy <= push;
          end
        end
        ST_START: begin
          bit_idx <= '0;
          if (bit_end) state <= ST_DATA;
        end
        ST_DATA: begin
          if (bit_end) begin
            bit_idx <= bit_idx + 1'b1;
`ifdef SERIAL_TX_PARITY_EN
            if (bit_idx == 3'd7) state <= ST_PARITY;
`else
            if (bit_idx == 3'd7) state <= ST_STOP;
`endif
          end
        end
`ifdef SERIAL_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_end) state <= ST_STOP;
        end
`endif
        ST_STOP: begin
          if (bit_end) begin
            if (!hi_sel) begin
              hi_sel <= 1'b1;
              state  <= ST_START;
            end else if (pop) begin
              hi_sel <= 1'b0;
              state  <= ST_START;
            end else begin
              state <= ST_IDLE;
              Busy  <= push;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          Busy  <= push;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_word_tx.sv
// tb_serial_word_tx
// Directed bench for serial_word_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// UART frames are sampled in the last cycle of each bit time.
module tb_serial_word_tx;

  localparam int CLKS  = 4;
  localparam int DEPTH = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int FRAME_CYC = FB * CLKS;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        SerialWrite = 1'b0;
  logic [15:0] SerialData = 16'h0000;
  logic        Tx;
  logic        Busy;
  logic        Full;
  logic        Overflow;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  serial_word_tx #(
    .CLKS_PER_BIT (CLKS),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .SerialWrite (SerialWrite),
    .SerialData  (SerialData),
    .Tx          (Tx),
    .Busy        (Busy),
    .Full        (Full),
    .Overflow    (Overflow)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  // Polls up to budget cycles for the start bit; -1 when none appears.
  task automatic find_start(input int budget, output int s);
    s = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (Tx === 1'b0) begin
        s = cyc;
        break;
      end
    end
  endtask

  task automatic check_frame(input string tag, input int s, input logic [7:0] exp_byte,
                             output logic [FB-1:0] raw);
    raw = '1;
    for (int k = 0; k < FB; k++) begin
      wait_until(s + k * CLKS + CLKS - 1);
      raw[k] = Tx;
    end
    check({tag, " start"}, 32'(s >= 0), 32'd1);
    check({tag, " start bit"}, 32'(raw[0]), 32'd0);
    check({tag, " data"}, 32'(raw[8:1]), 32'(exp_byte));
`ifdef SERIAL_TX_PARITY_EN
    check({tag, " parity"}, 32'(raw[9]), 32'(^exp_byte));
`endif
    check({tag, " stop bit"}, 32'(raw[FB-1]), 32'd1);
  endtask

  int s_prev, s_cur, wcyc;
  logic [FB-1:0] raw;
  logic [7:0] exp_b;

  initial begin
    // Reset state
    tick(); tick();
    check("rst Tx", 32'(Tx), 32'd1);
    check("rst Busy", 32'(Busy), 32'd0);
    check("rst Full", 32'(Full), 32'd0);
    check("rst Overflow", 32'(Overflow), 32'd0);
    Reset = 1'b1;
    tick(); tick();
    check("idle Tx", 32'(Tx), 32'd1);
    check("idle Busy", 32'(Busy), 32'd0);

    // Single word 0xA55A
    SerialWrite = 1'b1; SerialData = 16'hA55A;
    tick();
    SerialWrite = 1'b0;
    wcyc = cyc;
    check("w1 Busy after write", 32'(Busy), 32'd1);
    find_start(8, s_cur);
    check("w1 latency", 32'(s_cur - wcyc), 32'd2);
    check_frame("w1 lo", s_cur, 8'h5A, raw);
    s_prev = s_cur;
    find_start(3, s_cur);
    check("w1 byte gap", 32'(s_cur - s_prev), 32'(FRAME_CYC));
    check_frame("w1 hi", s_cur, 8'hA5, raw);
    wait_until(wcyc + 2 * FRAME_CYC + 1);
    check("w1 Busy dropped", 32'(Busy), 32'd0);
    check("w1 Tx idle", 32'(Tx), 32'd1);

    // Two words on consecutive cycles
    repeat (4) tick();
    SerialWrite = 1'b1; SerialData = 16'h0102;
    tick();
    SerialData = 16'h0304;
    tick();
    SerialWrite = 1'b0;
    find_start(8, s_cur);
    check_frame("w2 f0", s_cur, 8'h02, raw);
    s_prev = s_cur; find_start(3, s_cur);
    check("w2 gap1", 32'(s_cur - s_prev), 32'(FRAME_CYC));
    check_frame("w2 f1", s_cur, 8'h01, raw);
    s_prev = s_cur; find_start(3, s_cur);
    check("w2 gap2", 32'(s_cur - s_prev), 32'(FRAME_CYC));
    check_frame("w2 f2", s_cur, 8'h04, raw);
    s_prev = s_cur; find_start(3, s_cur);
    check("w2 gap3", 32'(s_cur - s_prev), 32'(FRAME_CYC));
    check_frame("w2 f3", s_cur, 8'h03, raw);
    tick(); tick();
    check("w2 Busy dropped", 32'(Busy), 32'd0);

    // Six back-to-back writes: five accepted, sixth dropped
    repeat (4) tick();
    wcyc = cyc + 1;
    SerialWrite = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      SerialData = 16'(16'h1001 * k);
      tick();
    end
    SerialWrite = 1'b0;
    check("ovf set", 32'(Overflow), 32'd1);
    check("ovf Full", 32'(Full), 32'd1);
    s_cur = wcyc + 2;
    for (int k = 1; k <= 5; k++) begin
      exp_b = 8'(k);
      check_frame("ovf lo", s_cur, exp_b, raw);
      s_prev = s_cur; find_start(3, s_cur);
      check("ovf gap lo", 32'(s_cur - s_prev), 32'(FRAME_CYC));
      exp_b = 8'(k * 16);
      check_frame("ovf hi", s_cur, exp_b, raw);
      if (k < 5) begin
        s_prev = s_cur; find_start(3, s_cur);
        check("ovf gap hi", 32'(s_cur - s_prev), 32'(FRAME_CYC));
      end
    end
    find_start(3 * FRAME_CYC, s_cur);
    check("ovf no sixth word", 32'(s_cur), 32'hFFFF_FFFF);
    check("ovf sticky", 32'(Overflow), 32'd1);
    check("ovf Full cleared", 32'(Full), 32'd0);
    check("ovf Busy dropped", 32'(Busy), 32'd0);

    // Reset during DATA of the first byte, with a second word buffered
    SerialWrite = 1'b1; SerialData = 16'h0000;
    tick();
    wcyc = cyc;
    tick();
    SerialWrite = 1'b0;
    wait_until(wcyc + 12);
    check("mid Tx low in data", 32'(Tx), 32'd0);
    Reset = 1'b0;
    #1;
    check("mid Tx async high", 32'(Tx), 32'd1);
    tick(); tick();
    Reset = 1'b1;
    tick();
    check("post Busy", 32'(Busy), 32'd0);
    check("post Full", 32'(Full), 32'd0);
    check("post Overflow", 32'(Overflow), 32'd0);
    check("post Tx", 32'(Tx), 32'd1);
    find_start(3 * FRAME_CYC, s_cur);
    check("post no frame", 32'(s_cur), 32'hFFFF_FFFF);
    check("post Busy idle", 32'(Busy), 32'd0);

`ifdef SERIAL_TX_PARITY_EN
    // Even parity on 0x0007
    SerialWrite = 1'b1; SerialData = 16'h0007;
    tick();
    SerialWrite = 1'b0;
    wcyc = cyc;
    find_start(8, s_cur);
    check("par latency", 32'(s_cur - wcyc), 32'd2);
    check_frame("par lo", s_cur, 8'h07, raw);
    check("par lo bit", 32'(raw[9]), 32'd1);
    s_prev = s_cur; find_start(3, s_cur);
    check("par frame len", 32'(s_cur - s_prev), 32'd44);
    check_frame("par hi", s_cur, 8'h00, raw);
    check("par hi bit", 32'(raw[9]), 32'd0);
    tick(); tick();
    check("par Busy dropped", 32'(Busy), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
